safe_code_controller: RTL and testbench
=======================================

// Module: safe_code_controller
// PURPOSE
//  Consumes the one-cycle key codes produced by the keypad membrane scanner.
//  Accumulates PIN digits and checks them against a stored code on '#'.
//  Drives the lock-release signal, counts failed attempts and enforces a
//  timed lockout. While open, the user can re-program the code.
// PARAMETERS
//  CODE_LEN        4         digits per PIN, legal range 1..7
//  DEFAULT_CODE    16'h1234  code after reset; 4*CODE_LEN bits, one BCD nibble per digit, first digit in MS nibble
//  MAX_FAILS       3         consecutive failed checks before lockout, 1..15
//  LOCKOUT_CYCLES  1024      lockout duration in clk cycles, 1..2^24-1
//  OPEN_CYCLES     0         auto-relock timeout in cycles; 0 disables the timeout; max 2^24-1
// PORTS
//  clk             in   1           system clock, same clock as the scanner
//  rst             in   1           asynchronous, active-low reset
//  key_code        in   4           scanner output: 0-9 digit, 10 '#', 11 '*', 13 idle; 12/14/15 ignored
//  unlocked        out  1           1 while in OPEN
//  lockout         out  1           1 while in LOCKOUT
//  digit_count     out  3           digits currently buffered, 0..CODE_LEN
//  ok_pulse        out  1           1-cycle pulse: a check succeeded
//  err_pulse       out  1           1-cycle pulse: a check or programming attempt failed
//  code_set_pulse  out  1           1-cycle pulse: a new code was stored
//  state           out  2           FSM state for debug: 0 LOCKED, 1 CHECK, 2 OPEN, 3 LOCKOUT
// BEHAVIOUR
//  Reset (rst=0, async): state=LOCKED, all outputs 0, buffer=0, overflow=0, fail_cnt=0,
//    timers=0, code_reg=DEFAULT_CODE. Codes are volatile.
//  Key event: any cycle with key_code<=11; each such cycle is one event (no edge detect).
//  Digit event (all states except CHECK and LOCKOUT):
//    count<CODE_LEN -> buf={buf<<4, digit}, count+1.
//    count==CODE_LEN -> set overflow, buffer unchanged.
//  Outputs are registered; digit_count updates the cycle after the key.
//  LOCKED:
//    '*' -> clear buf/count/overflow.
//    '#' -> CHECK next cycle.
//  CHECK (exactly 1 cycle, keys dropped):
//    match = count==CODE_LEN & !overflow & buf==code_reg.
//    match -> OPEN, ok_pulse, fail_cnt=0, open timer=OPEN_CYCLES.
//    else  -> err_pulse, fail_cnt+1; if fail_cnt+1==MAX_FAILS ->
//             LOCKOUT, timer=LOCKOUT_CYCLES; else LOCKED.
//    Buffer, count and overflow are cleared on exit.
//    ok_pulse/err_pulse assert 2 cycles after the '#' cycle.
//  OPEN: unlocked=1.
//    '*' -> LOCKED, buffer cleared.
//    '#' with count==CODE_LEN & !overflow -> code_reg=buf, code_set_pulse,
//        stay OPEN, buffer cleared.
//    '#' otherwise -> err_pulse, buffer cleared, stay OPEN; fail_cnt unchanged.
//    If OPEN_CYCLES!=0, the timer decrements every cycle; at 1->0 go to LOCKED.
//    Timeout and a key event in the same cycle: timeout wins and the key is dropped.
//  LOCKOUT: all keys ignored; timer decrements each cycle.
//    When the timer reaches 0 -> LOCKED, fail_cnt=0, lockout=0.
//    lockout is high for exactly LOCKOUT_CYCLES cycles.
//  Pulses are never asserted together. At most one state transition per cycle.
//  Reset mid-entry or mid-lockout aborts immediately; nothing persists.
// TESTING
//  1. Reset, then keys 1,2,3,4,# (16-cycle spacing) -> ok_pulse 2 cycles after '#';
//     unlocked=1; digit_count=0.
//  2. Enter 1,2,3,5,# three times -> err_pulse x3; after the 3rd check lockout=1 for
//     1024 cycles, digit keys leave digit_count=0, then state=LOCKED and
//     1234# opens.
//  3. Enter 1,2,3,4,5,# -> err_pulse (overflow). Enter 9,*,1,2,3,4,# -> ok_pulse.
//  4. While OPEN: 5,6,7,8,# -> code_set_pulse; then '*' relocks; 1234# -> err_pulse;
//     5678# -> ok_pulse.
//  5. OPEN_CYCLES=100: open, then wait -> unlocked falls exactly 100 cycles after ok_pulse;
//     a digit key in the timeout cycle leaves digit_count=0.
//  6. Assert rst mid-entry (count=2) and mid-lockout -> outputs zero asynchronously;
//     code is back to 1234 after release.

Source files
------------

// File: rtl/safe_code_controller.sv
// PIN entry controller: buffers keypad digits, checks them against a stored code,
// drives the lock release, counts failed attempts and enforces a timed lockout.
module safe_code_controller #(
  parameter int unsigned                CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]      DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                MAX_FAILS      = 3,
  parameter int unsigned                LOCKOUT_CYCLES = 1024,
  parameter int unsigned                OPEN_CYCLES    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       lockout,
  output logic [2:0] digit_count,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic       code_set_pulse,
  output logic [1:0] state
);

  localparam int unsigned CW         = 4 * CODE_LEN;
  localparam logic [2:0]  FULL_CNT   = 3'(CODE_LEN);
  localparam logic [3:0]  FAIL_LIMIT = 4'(MAX_FAILS);
  localparam logic [23:0] LOCK_LOAD  = 24'(LOCKOUT_CYCLES);
  localparam logic [23:0] OPEN_LOAD  = 24'(OPEN_CYCLES);
  localparam bit          TIMED_OPEN = (OPEN_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  buf_q, buf_d;
  logic [CW-1:0]  code_q, code_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [3:0]     fail_q, fail_d;
  logic [23:0]    tmr_q, tmr_d;
  logic           ok_q, ok_d;
  logic           err_q, err_d;
  logic           set_q, set_d;

  logic           is_digit, is_hash, is_star;
  logic           full, entry_ok, match;
  logic [CW-1:0]  acc_buf;
  logic [2:0]     acc_cnt;
  logic           acc_ovf;
  logic [3:0]     fail_inc;

  assign is_digit = (key_code <= 4'd9);
  assign is_hash  = (key_code == 4'd10);
  assign is_star  = (key_code == 4'd11);
  assign full     = (cnt_q == FULL_CNT);
  assign entry_ok = full && !ovf_q;
  assign match    = entry_ok && (buf_q == code_q);
  assign fail_inc = fail_q + 4'd1;

  // A digit on a full buffer only marks overflow so the attempt is rejected later.
  always_comb begin
    acc_buf = buf_q;
    acc_cnt = cnt_q;
    acc_ovf = ovf_q;
    if (full) begin
      acc_ovf = 1'b1;
    end else begin
      acc_buf = (buf_q << 4) | CW'(key_code);
      acc_cnt = cnt_q + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    set_d   = 1'b0;

    unique case (state_q)
      ST_LOCKED: begin
        if (is_digit) begin
          buf_d = acc_buf;
          cnt_d = acc_cnt;
          ovf_d = acc_ovf;
        end else if (is_star) begin
          buf_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (is_hash) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        if (match) begin
          state_d = ST_OPEN;
          ok_d    = 1'b1;
          fail_d  = '0;
          tmr_d   = OPEN_LOAD;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            state_d = ST_LOCKOUT;
            tmr_d   = LOCK_LOAD;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end

      ST_OPEN: begin
        if (TIMED_OPEN) tmr_d = tmr_q - 24'd1;
        // Timeout takes priority over any key arriving in the same cycle.
        if (TIMED_OPEN && tmr_q <= 24'd1) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (is_digit) begin
          buf_d = acc_buf;
          cnt_d = acc_cnt;
          ovf_d = acc_ovf;
        end else if (is_star) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (is_hash) begin
          buf_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (entry_ok) begin
            code_d = buf_q;
            set_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        tmr_d = tmr_q - 24'd1;
        if (tmr_q <= 24'd1) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          fail_d  = '0;
        end
      end

      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fail_q  <= '0;
      tmr_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      set_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      set_q   <= set_d;
    end
  end

  assign unlocked       = (state_q == ST_OPEN);
  assign lockout        = (state_q == ST_LOCKOUT);
  assign digit_count    = cnt_q;
  assign ok_pulse       = ok_q;
  assign err_pulse      = err_q;
  assign code_set_pulse = set_q;
  assign state          = state_q;

endmodule

// File: tb/tb_safe_code_controller.sv
// Bench for safe_code_controller: two differently parameterised instances share one
// key stream and are compared every cycle against a digit-list / timestamp model.
module tb_safe_code_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_code = 4'd13;

  always #5 clk = ~clk;

  logic       u0, l0, ok0, er0, st0, u1, l1, ok1, er1, st1;
  logic [2:0] dc0, dc1;
  logic [1:0] s0, s1;
  logic [9:0] obs0, obs1;

  assign obs0 = {u0, l0, dc0, ok0, er0, st0, s0};
  assign obs1 = {u1, l1, dc1, ok1, er1, st1, s1};

  safe_code_controller #(
    .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_FAILS(3),
    .LOCKOUT_CYCLES(1024), .OPEN_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .key_code(key_code), .unlocked(u0), .lockout(l0),
    .digit_count(dc0), .ok_pulse(ok0), .err_pulse(er0), .code_set_pulse(st0), .state(s0)
  );

  safe_code_controller #(
    .CODE_LEN(3), .DEFAULT_CODE(12'h123), .MAX_FAILS(2),
    .LOCKOUT_CYCLES(37), .OPEN_CYCLES(100)
  ) dut1 (
    .clk(clk), .rst(rst), .key_code(key_code), .unlocked(u1), .lockout(l1),
    .digit_count(dc1), .ok_pulse(ok1), .err_pulse(er1), .code_set_pulse(st1), .state(s1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: per-instance parameters, entered digits as a list, timers as entry timestamps.
  int P_LEN[2] = '{4, 3};
  int P_MF[2]  = '{3, 2};
  int P_LC[2]  = '{1024, 37};
  int P_OC[2]  = '{0, 100};

  int m_mode[2];  // 0 LOCKED, 1 CHECK, 2 OPEN, 3 LOCKOUT
  int m_n[2];
  int m_fails[2];
  int m_open_at[2];
  int m_lock_at[2];
  bit m_ovf[2], m_ok[2], m_err[2], m_set[2];
  int m_dig[2][8];
  int m_code[2][8];
  int m_edge = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_n[i] = 0; m_fails[i] = 0; m_ovf[i] = 0;
      m_ok[i] = 0; m_err[i] = 0; m_set[i] = 0;
      for (int j = 0; j < 8; j++) m_code[i][j] = (j < P_LEN[i]) ? j + 1 : 0;
    end
  endtask

  task automatic clear_entry(int i);
    m_n[i] = 0;
    m_ovf[i] = 0;
  endtask

  task automatic add_digit(int i, int k);
    if (m_n[i] < P_LEN[i]) begin
      m_dig[i][m_n[i]] = k;
      m_n[i]++;
    end else begin
      m_ovf[i] = 1;
    end
  endtask

  task automatic model_step(int i, int k);
    bit good;
    m_ok[i] = 0; m_err[i] = 0; m_set[i] = 0;
    case (m_mode[i])
      0: begin
        if (k <= 9) add_digit(i, k);
        else if (k == 11) clear_entry(i);
        else if (k == 10) m_mode[i] = 1;
      end
      1: begin
        good = (m_n[i] == P_LEN[i]) && !m_ovf[i];
        for (int j = 0; j < P_LEN[i]; j++) if (m_dig[i][j] != m_code[i][j]) good = 0;
        clear_entry(i);
        if (good) begin
          m_mode[i] = 2; m_ok[i] = 1; m_fails[i] = 0; m_open_at[i] = m_edge;
        end else begin
          m_err[i] = 1;
          m_fails[i]++;
          if (m_fails[i] == P_MF[i]) begin
            m_mode[i] = 3; m_lock_at[i] = m_edge;
          end else begin
            m_mode[i] = 0;
          end
        end
      end
      2: begin
        if (P_OC[i] != 0 && m_edge == m_open_at[i] + P_OC[i]) begin
          m_mode[i] = 0; clear_entry(i);
        end else if (k <= 9) begin
          add_digit(i, k);
        end else if (k == 11) begin
          m_mode[i] = 0; clear_entry(i);
        end else if (k == 10) begin
          if (m_n[i] == P_LEN[i] && !m_ovf[i]) begin
            for (int j = 0; j < P_LEN[i]; j++) m_code[i][j] = m_dig[i][j];
            m_set[i] = 1;
          end else begin
            m_err[i] = 1;
          end
          clear_entry(i);
        end
      end
      default: begin
        if (m_edge == m_lock_at[i] + P_LC[i]) begin
          m_mode[i] = 0; m_fails[i] = 0;
        end
      end
    endcase
  endtask

  task automatic compare(int i, logic [9:0] got);
    logic [9:0] exp;
    exp = {m_mode[i] == 2, m_mode[i] == 3, 3'(m_n[i]), m_ok[i], m_err[i], m_set[i], 2'(m_mode[i])};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL cycle_dut%0d at %0t: got %b want %b", i, $time, got, exp);
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      m_edge++;
      model_step(0, int'(key_code));
      model_step(1, int'(key_code));
    end
    #1;
    compare(0, obs0);
    compare(1, obs1);
  end

  task automatic hit(int k);
    @(negedge clk) key_code = 4'(k);
    @(negedge clk) key_code = 4'd13;
  endtask

  task automatic gap();
    repeat (14) @(negedge clk);
  endtask

  task automatic press(int k);
    hit(k);
    gap();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rkey(int k, int g);
    @(negedge clk) key_code = 4'(k);
    repeat (g) @(negedge clk) key_code = 4'd13;
  endtask

  initial begin
    int lc;
    int r, d;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", int'(s0), 0);
    chk("reset_outs", int'(obs0), 0);
    chk("reset_outs1", int'(obs1), 0);
    rst = 1'b1;

    // 1: correct code opens
    hit(1); chk("dc_after_1", int'(dc0), 1); gap();
    press(2); press(3);
    hit(4); chk("dc_after_4", int'(dc0), 4); gap();
    hit(10); @(negedge clk);
    chk("t1_ok", int'(ok0), 1); chk("t1_unlocked", int'(u0), 1); chk("t1_dc", int'(dc0), 0);
    gap();
    press(11);

    // 2: three wrong codes, lockout duration, then reopen
    for (int a = 0; a < 3; a++) begin
      press(1); press(2); press(3); press(5);
      hit(10); @(negedge clk);
      chk("t2_err", int'(er0), 1);
      if (a < 2) gap();
    end
    chk("t2_lockout", int'(l0), 1);
    lc = 0;
    while (l0 && lc < 2000) begin
      key_code = (lc % 50 == 10) ? 4'd7 : 4'd13;
      if (lc % 50 == 11) chk("t2_dc_locked", int'(dc0), 0);
      lc++;
      @(negedge clk);
    end
    key_code = 4'd13;
    chk("t2_lockout_len", lc, 1024);
    chk("t2_state", int'(s0), 0);
    chk("t2_dc", int'(dc0), 0);
    press(1); press(2); press(3); press(4);
    hit(10); @(negedge clk); chk("t2_reopen", int'(ok0), 1); gap();

    // 3: overflow rejected, '*' clears
    press(11);
    press(1); press(2); press(3); press(4); press(5);
    hit(10); @(negedge clk); chk("t3_ovf_err", int'(er0), 1); gap();
    press(9); press(11); press(1); press(2); press(3); press(4);
    hit(10); @(negedge clk); chk("t3_ok", int'(ok0), 1); gap();

    // 4: reprogram while open
    press(5); press(6); press(7); press(8);
    hit(10); chk("t4_set", int'(st0), 1); chk("t4_open", int'(s0), 2); gap();
    hit(11); chk("t4_relock", int'(s0), 0); gap();
    press(1); press(2); press(3); press(4);
    hit(10); @(negedge clk); chk("t4_old_err", int'(er0), 1); gap();
    press(5); press(6); press(7); press(8);
    hit(10); @(negedge clk); chk("t4_new_ok", int'(ok0), 1); gap();

    // 5: auto-relock on dut1, digit in timeout cycle dropped
    do_reset();
    press(1); press(2); press(3);
    hit(10); @(negedge clk);
    chk("t5_ok", int'(ok1), 1);
    lc = 0;
    while (u1 && lc < 300) begin
      key_code = (lc == 99) ? 4'd5 : 4'd13;
      lc++;
      @(negedge clk);
    end
    key_code = 4'd13;
    chk("t5_open_len", lc, 100);
    chk("t5_dc", int'(dc1), 0);
    chk("t5_state", int'(s1), 0);

    // 6: async reset mid-entry and mid-lockout
    do_reset();
    press(1); press(2);
    chk("t6_dc2", int'(dc0), 2);
    @(negedge clk); #2 rst = 1'b0; #1;
    chk("t6_async_dc", int'(dc0), 0);
    chk("t6_async_outs", int'(obs0), 0);
    @(negedge clk) rst = 1'b1;
    press(1); press(2); press(3); press(4);
    hit(10); @(negedge clk); chk("t6_code_back", int'(ok0), 1); gap();
    press(11);
    for (int a = 0; a < 3; a++) begin
      press(1); press(1); press(1); press(1); press(10);
    end
    chk("t6_in_lockout", int'(l0), 1);
    #2 rst = 1'b0; #1;
    chk("t6_async_lockout", int'(l0), 0);
    chk("t6_async_state", int'(s0), 0);
    @(negedge clk) rst = 1'b1;
    press(1); press(2); press(3); press(4);
    hit(10); @(negedge clk); chk("t6_after_lockout_rst", int'(ok0), 1); gap();

    // Randomised traffic, checked every cycle by the model
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 49);
      if (r < 20) begin
        d = $urandom_range(0, 1);
        for (int j = 0; j < P_LEN[d]; j++) rkey(m_code[d][j], $urandom_range(0, 2));
        rkey(10, $urandom_range(0, 3));
      end else if (r < 44) begin
        rkey($urandom_range(0, 15), $urandom_range(0, 2));
      end else if (r < 48) begin
        rkey(11, $urandom_range(0, 2));
      end else begin
        do_reset();
      end
    end
    key_code = 4'd13;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
